// File: rtl/cond_inv_seq.sv
// cond_inv_seq: chunk-serial conditional inverter (pass / invert / negate / xor).
// Processes CHUNK bits per cycle, rippling a carry between chunks so that
// negation needs no full-width adder.
// Optional macro COND_INV_OVF_DETECT_EN: flags negation of the most-negative value.
module cond_inv_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clkpos,
    input  logic             rstneg,
    input  logic             vdd,
    input  logic             vss,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             busy,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q;
    logic [1:0]       mode_q;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [CHUNK-1:0] a_sl, b_sl, op_sl;
    logic [CHUNK:0]   sum;
    logic             last, accept, finish;

    // Supply rails carry no logic function.
    logic unused_rails;
    assign unused_rails = vdd ^ vss;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);

    assign accept = (state == IDLE) && in_valid;
    assign last   = (cnt == CW'(NCHUNK - 1));
    assign finish = (state == RUN) && last;

    assign a_sl = a_q[cnt*CHUNK +: CHUNK];
    assign b_sl = b_q[cnt*CHUNK +: CHUNK];

    // Per-chunk operand selection and carry-in add.
    always_comb begin
        op_sl = a_sl;
        case (mode_q)
            2'b00:   op_sl = a_sl;
            2'b01,
            2'b10:   op_sl = ~a_sl;
            2'b11:   op_sl = a_sl ^ b_sl;
            default: op_sl = a_sl;
        endcase
        sum = {1'b0, op_sl} + {{CHUNK{1'b0}}, carry};
    end

    // Control FSM and result datapath; one chunk retired per RUN cycle.
    always_ff @(posedge clkpos or negedge rstneg) begin
        if (!rstneg) begin
            state  <= IDLE;
            out    <= '0;
            cout   <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= a;
                        b_q    <= b;
                        mode_q <= mode;
                        out    <= '0;
                        cout   <= 1'b0;
                        // +1 of two's complement enters as the chunk-0 carry-in.
                        carry  <= (mode == 2'b10);
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    out[cnt*CHUNK +: CHUNK] <= sum[CHUNK-1:0];
                    carry <= sum[CHUNK];
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        cout  <= sum[CHUNK];
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef COND_INV_OVF_DETECT_EN
    logic ovf_flag;

    // Overflow flag: captured on accept, published when the result lands.
    always_ff @(posedge clkpos or negedge rstneg) begin
        if (!rstneg) begin
            ovf_flag <= 1'b0;
            ovf      <= 1'b0;
        end else if (accept) begin
            ovf_flag <= (mode == 2'b10) && (a == {1'b1, {(WIDTH-1){1'b0}}});
            ovf      <= 1'b0;
        end else if (finish) begin
            ovf      <= ovf_flag;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cond_inv_seq.sv
// tb_cond_inv_seq: scoreboard bench for cond_inv_seq (WIDTH=16, CHUNK=4).
module tb_cond_inv_seq;

    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    logic         clkpos = 1'b0;
    logic         rstneg = 1'b0;
    logic         vdd = 1'b1;
    logic         vss = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   mode = 2'b00;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out;
    logic         cout;
    logic         busy;
    logic         ovf;

    cond_inv_seq #(.WIDTH(W), .CHUNK(C)) dut (
        .clkpos(clkpos), .rstneg(rstneg), .vdd(vdd), .vss(vss),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .cout(cout), .busy(busy), .ovf(ovf)
    );

    always #5 clkpos = ~clkpos;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         o;
    } exp_t;

    exp_t sbq[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    bit   rand_rdy  = 1'b0;
    logic rdy_force = 1'b1;

    // Reference: whole-word arithmetic straight from the mode table.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [1:0] m);
        exp_t e;
        longint unsigned full, r;
        full  = longint'(1) << W;
        e.c   = 1'b0;
        e.o   = 1'b0;
        e.res = x;
        case (m)
            2'd0: e.res = x;
            2'd1: e.res = W'((full - 1) - longint'(x));
            2'd2: begin
                r     = full - longint'(x);
                e.res = r[W-1:0];
                e.c   = (r == full);
`ifdef COND_INV_OVF_DETECT_EN
                e.o   = (longint'(x) == (full >> 1));
`endif
            end
            default: e.res = x ^ y;
        endcase
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Consumer ready: random when enabled, otherwise forced level.
    always @(posedge clkpos) begin
        #1;
        out_ready = rand_rdy ? 1'($urandom % 2) : rdy_force;
    end

    // Monitor: every handshaked result is matched against the scoreboard head.
    always @(negedge clkpos) begin
        if (rstneg && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_result", 64'(out), 64'hDEAD);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("out", 64'(out), 64'(e.res));
                check("cout", 64'(cout), 64'(e.c));
                check("ovf", 64'(ovf), 64'(e.o));
            end
        end
    end

    // Present a request, wait for acceptance, then scramble the inputs.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] m);
        int t;
        bit ok;
        t  = 0;
        ok = 1'b0;
        @(posedge clkpos); #1;
        a = x; b = y; mode = m; in_valid = 1'b1;
        while (!ok && t < 200) begin
            @(negedge clkpos);
            if (in_ready) ok = 1'b1;
            t++;
        end
        if (!ok) begin
            check("accept_timeout", 64'(t), 64'(0));
            in_valid = 1'b0;
        end else begin
            sbq.push_back(model(x, y, m));
            @(posedge clkpos); #1;
            in_valid = 1'b0;
            a = W'($urandom); b = W'($urandom); mode = 2'($urandom);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        forever begin
            @(negedge clkpos);
            if (out_valid || n >= 100) break;
            n++;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 2000) begin
            @(negedge clkpos);
            t++;
        end
        check("drain_empty", 64'(sbq.size()), 64'(0));
    endtask

    initial begin
        int n;
        logic [W-1:0] held;
        bit seen;

        // Reset values
        repeat (3) @(posedge clkpos);
        @(negedge clkpos);
        check("rst_out", 64'(out), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_cout", 64'(cout), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_ovf", 64'(ovf), 64'(0));
        @(posedge clkpos); #1;
        rstneg = 1'b1;

        // Invert with latency check
        rdy_force = 1'b1;
        issue(16'h00FF, 16'h0000, 2'b01);
        wait_valid(n);
        check("latency", 64'(n), 64'(N));
        @(negedge clkpos);
        check("in_ready_after", 64'(in_ready), 64'(1));

        // Directed mode coverage
        issue(16'h0001, 16'h0000, 2'b10);
        issue(16'h0000, 16'h0000, 2'b10);
        issue(16'hAAAA, 16'h0F0F, 2'b11);
        issue(16'h1234, 16'hFFFF, 2'b00);
        issue(16'hFFFF, 16'h0000, 2'b10);
        drain();

        // Backpressure: held result, new requests ignored
        rdy_force = 1'b0;
        issue(W'($urandom), W'($urandom), 2'b10);
        wait_valid(n);
        held = out;
        for (int i = 0; i < 5; i++) begin
            @(posedge clkpos); #1;
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom); mode = 2'b01;
            @(negedge clkpos);
            check("bp_out_stable", 64'(out), 64'(held));
            check("bp_in_ready", 64'(in_ready), 64'(0));
        end
        rdy_force = 1'b1;
        @(negedge clkpos);
        @(negedge clkpos);
        check("bp_idle_valid", 64'(out_valid), 64'(0));
        check("bp_idle_ready", 64'(in_ready), 64'(1));
        sbq.push_back(model(a, b, mode));
        @(posedge clkpos); #1;
        in_valid = 1'b0;
        @(negedge clkpos);
        check("bp_accepted", 64'(busy), 64'(1));
        drain();

        // Reset during RUN chunk 2
        issue(W'($urandom) | 16'h0001, 16'h0000, 2'b10);
        @(posedge clkpos);
        @(posedge clkpos); #1;
        rstneg = 1'b0;
        #1;
        void'(sbq.pop_back());
        check("mid_rst_out", 64'(out), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clkpos);
        rstneg = 1'b1;
        seen = 1'b0;
        repeat (N + 2) begin
            @(negedge clkpos);
            if (out_valid) seen = 1'b1;
        end
        check("mid_rst_no_valid", 64'(seen), 64'(0));
        issue(16'h8000, 16'h0000, 2'b10);
        drain();

        // Randomized traffic with random consumer stalls
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            issue(W'($urandom), W'($urandom), 2'($urandom));
            if ($urandom % 4 == 0) repeat ($urandom_range(1, 3)) @(posedge clkpos);
        end
        rand_rdy  = 1'b0;
        rdy_force = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/cond_inv_seq.md
Name: cond_inv_seq

Overview:
- Parametrised, chunk-serial successor to the fixed 16-bit conditional inverter in the MIPS25 adiabatic ALU library.
- Takes a WIDTH-bit operand and a 2-bit mode, and produces one of: pass, one's complement, two's complement, or a per-bit XOR mask.
- Processes CHUNK bits per cycle, rippling a carry between chunks so negation needs no full-width adder.
- Sits between the operand latches and the adder/subtractor, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; NCHUNK = WIDTH/CHUNK; NCHUNK ≥ 1.

Ports:
- clkpos  input  1  sole clock; all state updates on the rising edge.
- rstneg  input  1  asynchronous, active-low reset.
- vdd  input  1  supply rail; no logic function.
- vss  input  1  supply rail; no logic function.
- in_valid  input  1  request present.
- in_ready  output  1  block accepts a request this cycle.
- a  input  WIDTH  operand.
- b  input  WIDTH  per-bit invert mask; used only in mode 11.
- mode  input  2  00 pass, 01 invert (~a), 10 negate (~a+1), 11 xor (a^b).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out  output  WIDTH  result.
- cout  output  1  final carry; 1 only for negate of zero.
- busy  output  1  state is not IDLE.
- ovf  output  1  negate overflow (see Optional Feature).

Behaviour:
- Clock and reset are fixed: one clock, clkpos; reset rstneg is asynchronous and active-low.
- Reset values: state=IDLE, out=0, cout=0, ovf=0, out_valid=0, busy=0, chunk counter=0. in_ready reads 1 once the block is in IDLE.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge: latch a, b and mode; clear out; set carry to (mode==10); counter=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each edge processes chunk k = counter, where slice = bits [k*CHUNK +: CHUNK].
  - op(slice) is: a (mode 00), ~a (mode 01), ~a (mode 10), a^b (mode 11).
  - {c, out[slice]} = op(slice) + carry.
  - carry ← c; counter ← counter+1.
  - After chunk NCHUNK-1: cout ← final carry; go to HOLD.
- HOLD:
  - out_valid=1; out, cout and ovf held stable.
  - When out_ready is high at an edge: go to IDLE and drop out_valid. out keeps its value until the next accept.
- Latency:
  - out_valid rises NCHUNK cycles after the accepting edge.
  - Minimum request-to-request interval is NCHUNK+2 cycles.
- Carry only ever propagates in mode 10; cout is 0 in modes 00, 01 and 11.
- Input changes after acceptance are ignored. in_valid while busy is ignored and not queued.
- out_ready outside HOLD is ignored.
- rstneg asserted in any state, including mid-RUN: immediate return to reset values. The partial result is discarded and no out_valid is produced.
- NCHUNK==1: RUN lasts exactly one cycle.
- Counter width is clog2(NCHUNK), minimum 1. The counter wraps only via the reset to 0 on accept.

Optional Feature:
- Macro COND_INV_OVF_DETECT_EN.
- Defined:
  - On accept, record whether mode==10 and a == 1<<(WIDTH-1) (most-negative value).
  - ovf ← that flag when entering HOLD; otherwise ovf=0.
  - ovf is cleared on the next accept.
- Undefined: ovf is tied to 0 and no extra state is built.

Test Plan:
- Reset (WIDTH=16, CHUNK=4), hold rstneg=0 then release -> out=0, out_valid=0, cout=0, busy=0, in_ready=1.
- mode=01, a=16'h00FF, out_ready=1 -> out_valid rises 4 cycles after accept; out=16'hFF00, cout=0; in_ready back to 1 one cycle later.
- mode=10, a=16'h0001 -> out=16'hFFFF, cout=0. Then mode=10, a=16'h0000 -> out=16'h0000, cout=1.
- mode=11, a=16'hAAAA, b=16'h0F0F -> out=16'hA5A5. Then mode=00, a=16'h1234 -> out=16'h1234.
- Backpressure: result in HOLD with out_ready=0 for 5 cycles while in_valid=1, a changing -> out stable, in_ready=0, no new accept. Then out_ready=1 -> IDLE next cycle, and the new request is accepted on the following edge.
- rstneg pulsed low during RUN chunk 2 of a negate -> outputs reset immediately. A following mode=10, a=16'h8000 -> out=16'h8000; ovf=1 with COND_INV_OVF_DETECT_EN, ovf=0 without.
